alu_pipe: RTL and testbench

- Parametrised, registered successor to the team's 8-bit combinational ALU. It generalises the datapath to WIDTH bits and adds a status-flag register (C/Z/N/V) and carry-chained ops (ADC/SBB) for multi-word arithmetic.
- Adds a multi-cycle barrel-free shifter (one bit per cycle) and a compare op.
- Sits between the register file/decoder and the writeback stage, with valid/ready handshakes on both sides.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_core.sv | 47 ++++
 rtl/alu_pipe.sv | 107 ++++++++++
 tb/tb_alu_pipe.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM states shared by the alu_pipe slice
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_NAND = 4'b0100,
    OP_NOR  = 4'b0101,
    OP_NOT  = 4'b0110,
    OP_XOR  = 4'b0111,
    OP_XNOR = 4'b1000,
    OP_ADC  = 4'b1001,
    OP_SBB  = 4'b1010,
    OP_SHL  = 4'b1011,
    OP_SHR  = 4'b1100,
    OP_SAR  = 4'b1101,
    OP_CMP  = 4'b1110,
    OP_RSVD = 4'b1111
  } alu_op_e;
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
  function automatic logic is_shift(alu_op_e op);
    return op inside {OP_SHL, OP_SHR, OP_SAR};
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational result, carry and overflow for every non-shift opcode
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  input  logic             c_in,
  input  logic             c_flag,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             v
);
  localparam int M = WIDTH - 1;
  logic             sub;
  logic             ci;
  logic [WIDTH:0]   s;
  // one shared WIDTH+1 bit adder; subtraction is A + ~B + carry
  always_comb begin
    sub = op inside {OP_SUB, OP_SBB, OP_CMP};
    ci  = (op == OP_ADD) ? c_in : (op inside {OP_ADC, OP_SBB}) ? c_flag : sub;
    s   = {1'b0, a} + {1'b0, sub ? ~b : b} + {{WIDTH{1'b0}}, ci};
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        r = s[M:0];
        c = s[WIDTH];
        v = (a[M] == b[M]) && (s[M] != a[M]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        r = s[M:0];
        c = s[WIDTH];
        v = (a[M] != b[M]) && (s[M] != a[M]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_NOT:  r = ~a;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      default: r = '0;
    endcase
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with flag register, one-bit-per-cycle shifter and valid/ready handshakes
module alu_pipe import alu_pkg::*; #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [3:0]       flags
);
  localparam int M = WIDTH - 1;
  state_e             state_q, state_d;
  alu_op_e            op_q, op_d;
  logic [WIDTH-1:0]   sh_q, sh_d, y_q, y_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   r, sh_nx;
  logic               c, v, sh_out, accept;
  alu_op_e            op_in;
  logic [SHAMT_W-1:0] amt;
  assign op_in     = alu_op_e'(sel);
  assign amt       = B[SHAMT_W-1:0];
  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign Y         = y_q;
  assign flags     = flags_q;
  assign out_valid = out_valid_q;
  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (A),
    .b      (B),
    .op     (op_in),
    .c_in   (c_in),
    .c_flag (flags_q[FLAG_C]),
    .r      (r),
    .c      (c),
    .v      (v)
  );
  // single shift step of the working register; sh_out is the bit falling off
  always_comb begin
    sh_nx  = (op_q == OP_SHL) ? {sh_q[M-1:0], 1'b0} : {(op_q == OP_SAR) & sh_q[M], sh_q[M:1]};
    sh_out = (op_q == OP_SHL) ? sh_q[M] : sh_q[0];
  end
  // IDLE/SHIFT sequencing; every result load updates Y, flags and out_valid together
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !out_ready;
    if (state_q == ST_SHIFT) begin
      sh_d  = sh_nx;
      cnt_d = cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) begin
        y_d         = sh_nx;
        flags_d     = {sh_out, sh_nx == '0, sh_nx[M], 1'b0};
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
    end else if (accept) begin
      if (is_shift(op_in) && amt != '0) begin
        state_d = ST_SHIFT;
        op_d    = op_in;
        sh_d    = A;
        cnt_d   = amt;
      end else if (is_shift(op_in)) begin
        y_d         = A;
        flags_d     = {1'b0, A == '0, A[M], 1'b0};
        out_valid_d = 1'b1;
      end else begin
        y_d         = (op_in == OP_CMP) ? A : r;
        flags_d     = {c, r == '0, r[M], v};
        out_valid_d = 1'b1;
      end
    end
  end
  // state and output registers; reset drops any shift in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      sh_q        <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed plus randomized checks of alu_pipe against a transaction-level model
module tb_alu_pipe;
  localparam int WIDTH = 8;
  logic             clk, rst, in_valid, in_ready, c_in, out_valid, out_ready;
  logic [WIDTH-1:0] A, B, Y;
  logic [3:0]       sel, flags;
  typedef struct {int y; int f; int vis;} res_t;
  res_t q[$];
  int   cyc, busy_until, model_c, n_cmp, n_err;
  bit   accepted;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .flags     (flags)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not end, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // arithmetic reference: signed range test for V, integer carry for C
  function automatic void ref_op(input int op, input int a, input int b, input int ci, input int cf,
                                 output int y, output int f, output int n);
    int sa, sb, s, sv, r, c, v;
    sa = a > 127 ? a - 256 : a;
    sb = b > 127 ? b - 256 : b;
    s = 0; sv = 0; r = 0; c = 0; v = 0; n = 0;
    case (op)
      0:     begin s = a + b + ci;       sv = sa + sb + ci; end
      9:     begin s = a + b + cf;       sv = sa + sb + cf; end
      1, 14: begin s = a + 256 - b;      sv = sa - sb; end
      10:    begin s = a + 255 - b + cf; sv = sa - sb - 1 + cf; end
      2: r = a & b;
      3: r = a | b;
      4: r = 255 - (a & b);
      5: r = 255 - (a | b);
      6: r = 255 - a;
      7: r = a ^ b;
      8: r = 255 - (a ^ b);
      11: begin n = b % 8; r = (a << n) % 256;   c = n != 0 ? (a >> (8 - n)) % 2 : 0; end
      12: begin n = b % 8; r = a >> n;           c = n != 0 ? (a >> (n - 1)) % 2 : 0; end
      13: begin n = b % 8; r = (sa >>> n) & 255; c = n != 0 ? (sa >>> (n - 1)) & 1 : 0; end
      default: r = 0;
    endcase
    if (op inside {0, 1, 9, 10, 14}) begin
      r = s % 256;
      c = s / 256;
      v = (sv > 127 || sv < -128) ? 1 : 0;
    end
    y = (op == 14) ? a : r;
    f = c * 8 + (r == 0 ? 4 : 0) + (r / 128) * 2 + v;
  endfunction

  // one clock: check outputs at the falling edge, update the model, return just after the rising edge
  task automatic tick();
    bit exp_v, exp_r;
    int y, f, n;
    @(negedge clk);
    exp_v = q.size() > 0 && cyc >= q[0].vis;
    exp_r = cyc >= busy_until && (!exp_v || out_ready);
    chk("out_valid", out_valid, exp_v);
    chk("in_ready", in_ready, exp_r);
    if (exp_v) begin
      chk("Y", Y, q[0].y);
      chk("flags", flags, q[0].f);
      if (out_ready) void'(q.pop_front());
    end
    accepted = in_valid && exp_r;
    if (accepted) begin
      ref_op(int'(sel), int'(A), int'(B), int'(c_in), model_c, y, f, n);
      q.push_back('{y: y, f: f, vis: cyc + 1 + n});
      busy_until = cyc + 1 + n;
      model_c = f / 8;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci);
    sel = op; A = a; B = b; c_in = ci; in_valid = 1;
    accepted = 0;
    for (int i = 0; i < 40 && !accepted; i++) tick();
    if (!accepted) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst = 1;
    #1;
    chk("rst_Y", Y, 0);
    chk("rst_flags", flags, 0);
    chk("rst_out_valid", out_valid, 0);
    q.delete();
    busy_until = 0;
    model_c = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; busy_until = 0; model_c = 0; accepted = 0;
    rst = 1; in_valid = 0; out_ready = 1; A = 0; B = 0; sel = 0; c_in = 0;
    do_reset();
    tick();
    send(4'b0000, 8'h7F, 8'h01, 0);
    chk("t1_Y", Y, 8'h80);
    chk("t1_flags", flags, 4'b0011);
    send(4'b0001, 8'h00, 8'h01, 0);
    chk("t2_sub_Y", Y, 8'hFF);
    chk("t2_sub_flags", flags, 4'b0010);
    send(4'b1010, 8'h01, 8'h00, 0);
    chk("t2_sbb_Y", Y, 8'h00);
    chk("t2_sbb_flags", flags, 4'b1100);
    send(4'b1011, 8'h81, 8'h03, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("t3_shl_valid", out_valid, 1);
    chk("t3_shl_Y", Y, 8'h08);
    chk("t3_shl_flags", flags, 4'b0000);
    send(4'b1101, 8'h80, 8'h07, 0);
    for (int i = 0; i < 7; i++) tick();
    chk("t3_sar_Y", Y, 8'hFF);
    chk("t3_sar_flags", flags, 4'b0010);
    tick();
    out_ready = 0;
    send(4'b0010, 8'hF0, 8'h3C, 0);
    chk("t4_and_Y", Y, 8'h30);
    sel = 4'b0000; A = 8'h01; B = 8'h01; c_in = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("t4_held_Y", Y, 8'h30);
    chk("t4_held_ready", in_ready, 0);
    out_ready = 1;
    tick();
    in_valid = 0;
    chk("t4_second_accepted", accepted, 1);
    chk("t4_second_Y", Y, 8'h02);
    send(4'b1100, 8'hFF, 8'h05, 0);
    tick();
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    chk("t5_no_stale", out_valid, 0);
    send(4'b1110, 8'h10, 8'h10, 0);
    chk("t6_cmp_Y", Y, 8'h10);
    chk("t6_cmp_flags", flags, 4'b1100);
    send(4'b1111, 8'hA5, 8'h5A, 1);
    chk("t6_rsvd_Y", Y, 8'h00);
    chk("t6_rsvd_flags", flags, 4'b0100);
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom % 4) != 0;
      sel       = 4'($urandom);
      A         = 8'($urandom);
      B         = 8'($urandom);
      c_in      = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 12; i++) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
